shift_reg_ctrl: RTL and testbench

Sequencing controller for the serial shift-register datapath. It accepts a parallel word over a valid/ready handshake, loads it, and shifts it out one bit per bit period on `sout`. On the same bit boundaries it shifts `sin` in, and presents the captured word on `rx_data` with a one-cycle `rx_valid` pulse. It sits between a parallel producer/consumer and a serial link. It owns bit timing, bit counting, direction and abort.

---
 rtl/shift_ctrl_pkg.sv | 20 ++
 rtl/shift_reg_core.sv | 32 +++
 rtl/shift_reg_ctrl.sv | 137 +++++++++++++
 tb/tb_shift_reg_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared types and sizing helpers for the serial shift-register controller.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_WIDTH  = 4;
    localparam int unsigned DEF_DIV    = 1;
    localparam int unsigned DEF_BIT_CW = cnt_width(DEF_WIDTH);
    localparam int unsigned DEF_DIV_CW = cnt_width(DEF_DIV);

endpackage

// File: rtl/shift_reg_core.sv
// Parallel-load bidirectional shift register. dir=1 shifts toward the MSB (MSB is the head),
// dir=0 shifts toward the LSB (LSB is the head); ser_in enters at the opposite end.
module shift_reg_core
    import shift_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             dir,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             head
);

    // Load has priority over shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= dir ? {q[WIDTH-2:0], ser_in} : {ser_in, q[WIDTH-1:1]};
        end
    end

    assign head = dir ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/shift_reg_ctrl.sv
// Sequencing controller: accepts a word, shifts it out on sout while shifting sin in,
// then presents the received word on rx_data with a one-cycle rx_valid pulse.
module shift_reg_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DIV   = DEF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             msb_first,
    output logic             in_ready,
    input  logic             abort,
    input  logic             sin,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid
);

    localparam int unsigned BitCw = cnt_width(WIDTH);
    localparam int unsigned DivCw = cnt_width(DIV);
    localparam logic [BitCw-1:0] BitLast = BitCw'(WIDTH - 1);
    localparam logic [DivCw-1:0] DivLast = DivCw'(DIV - 1);

    shift_state_t     state_q, state_d;
    logic [BitCw-1:0] bit_cnt_q, bit_cnt_d;
    logic [DivCw-1:0] div_cnt_q, div_cnt_d;
    logic             msb_q, msb_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             sout_q, sout_d;

    logic             accept;
    logic             tick;
    logic             last_tick;
    logic [WIDTH-1:0] core_q;
    logic             core_head;
    logic [WIDTH-1:0] shifted;

    assign in_ready  = (state_q == IDLE) && !abort;
    assign accept    = in_valid && in_ready;
    assign tick      = (state_q == SHIFT) && (div_cnt_q == DivLast);
    assign last_tick = tick && (bit_cnt_q == BitLast);
    // Register contents after this tick's shift; captured as the received word on the last tick.
    assign shifted   = msb_q ? {core_q[WIDTH-2:0], sin} : {sin, core_q[WIDTH-1:1]};

    shift_reg_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_data (in_data),
        .shift     (tick && !abort),
        .dir       (msb_q),
        .ser_in    (sin),
        .q         (core_q),
        .head      (core_head)
    );

    // Next-state, counter, capture and registered-sout logic.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        msb_d     = msb_q;
        rx_data_d = rx_data_q;
        sout_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SHIFT;
                    msb_d     = msb_first;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    sout_d    = msb_first ? in_data[WIDTH-1] : in_data[0];
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                end else if (tick) begin
                    div_cnt_d = '0;
                    if (last_tick) begin
                        state_d   = DONE;
                        bit_cnt_d = '0;
                        rx_data_d = shifted;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        // Head bit after the shift lands this edge.
                        sout_d    = msb_q ? core_q[WIDTH-2] : core_q[1];
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                    sout_d    = core_head;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            msb_q     <= 1'b0;
            rx_data_q <= '0;
            sout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            msb_q     <= msb_d;
            rx_data_q <= rx_data_d;
            sout_q    <= sout_d;
        end
    end

    assign sout       = sout_q;
    assign sout_valid = (state_q == SHIFT);
    assign busy       = (state_q != IDLE);
    assign rx_valid   = (state_q == DONE);
    assign rx_data    = rx_data_q;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Self-checking bench: a DIV=3 instance driven with external sin against a transaction-level
// model, and a DIV=1 instance in loopback.
module tb_shift_reg_ctrl;

    localparam int unsigned W = 4;
    localparam int unsigned D = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DIV=3 instance
    logic         in_valid, in_ready, msb_first, abort, sin;
    logic         sout, sout_valid, busy, rx_valid;
    logic [W-1:0] in_data, rx_data;

    // DIV=1 instance, loopback
    logic         b_in_valid, b_in_ready, b_msb_first, b_abort, b_sin;
    logic         b_sout, b_sout_valid, b_busy, b_rx_valid;
    logic [W-1:0] b_in_data, b_rx_data;

    assign b_sin = b_sout;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_rx = '0;

    shift_reg_ctrl #(.WIDTH(W), .DIV(D)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .msb_first  (msb_first),
        .in_ready   (in_ready),
        .abort      (abort),
        .sin        (sin),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid)
    );

    shift_reg_ctrl #(.WIDTH(W), .DIV(1)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (b_in_valid),
        .in_data    (b_in_data),
        .msb_first  (b_msb_first),
        .in_ready   (b_in_ready),
        .abort      (b_abort),
        .sin        (b_sin),
        .sout       (b_sout),
        .sout_valid (b_sout_valid),
        .busy       (b_busy),
        .rx_data    (b_rx_data),
        .rx_valid   (b_rx_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at the negedge of an idle cycle; returns at the negedge of the next idle cycle.
    // mode 0: complete transfer, 1: abort during bit ab_bit, 2: reset during DONE.
    task automatic xfer(input logic [W-1:0] data, input logic msb, input logic [W-1:0] sin_bits,
                        input int mode, input int unsigned ab_bit);
        logic [W-1:0] rx;
        int unsigned  ab_t;
        int unsigned  i;
        rx        = '0;
        ab_t      = ab_bit * D + 1 + $urandom_range(0, D - 1);
        abort     = 1'b0;
        in_valid  = 1'b1;
        in_data   = data;
        msb_first = msb;
        sin       = 1'b0;
        #1 check("in_ready_accept", 32'(in_ready), 32'd1);
        for (int unsigned t = 1; t <= W * D + 2; t++) begin
            @(negedge clk);
            if (t <= W * D) begin
                i = (t - 1) / D;
                check("sout", 32'(sout), 32'(msb ? data[W-1-i] : data[i]));
                check("sout_valid", 32'(sout_valid), 32'd1);
                check("busy_shift", 32'(busy), 32'd1);
                check("rx_valid_shift", 32'(rx_valid), 32'd0);
                check("in_ready_shift", 32'(in_ready), 32'd0);
                // Ignored inputs wander during the transfer.
                in_valid  = 1'($urandom_range(0, 1));
                in_data   = W'($urandom);
                msb_first = 1'($urandom_range(0, 1));
                sin       = sin_bits[i];
                if (t % D == 0) rx[msb ? W-1-i : i] = sin_bits[i];
                if (mode == 1 && t == ab_t) begin
                    abort = 1'b1;
                    @(negedge clk);
                    check("abort_busy", 32'(busy), 32'd0);
                    check("abort_sout", 32'(sout), 32'd0);
                    check("abort_sout_valid", 32'(sout_valid), 32'd0);
                    check("abort_rx_valid", 32'(rx_valid), 32'd0);
                    check("abort_rx_data", 32'(rx_data), 32'(exp_rx));
                    abort    = 1'b0;
                    in_valid = 1'b0;
                    #1 check("abort_in_ready", 32'(in_ready), 32'd1);
                    return;
                end
            end else if (t == W * D + 1) begin
                check("rx_valid_done", 32'(rx_valid), 32'd1);
                check("rx_data_done", 32'(rx_data), 32'(rx));
                check("sout_valid_done", 32'(sout_valid), 32'd0);
                check("sout_done", 32'(sout), 32'd0);
                check("busy_done", 32'(busy), 32'd1);
                abort = 1'($urandom_range(0, 1));
                if (mode == 2) begin
                    rst = 1'b1;
                    @(negedge clk);
                    check("rst_done_rx_valid", 32'(rx_valid), 32'd0);
                    check("rst_done_rx_data", 32'(rx_data), 32'd0);
                    check("rst_done_busy", 32'(busy), 32'd0);
                    check("rst_done_sout", 32'(sout), 32'd0);
                    rst      = 1'b0;
                    abort    = 1'b0;
                    in_valid = 1'b0;
                    exp_rx   = '0;
                    return;
                end
                exp_rx = rx;
            end else begin
                check("rx_valid_idle", 32'(rx_valid), 32'd0);
                check("busy_idle", 32'(busy), 32'd0);
                check("sout_valid_idle", 32'(sout_valid), 32'd0);
                in_valid = 1'b0;
                abort    = 1'b0;
                #1 check("in_ready_return", 32'(in_ready), 32'd1);
            end
        end
    endtask

    // Loopback on the DIV=1 instance: received word must equal the sent word.
    task automatic loop1(input logic [W-1:0] data, input logic msb);
        b_in_valid  = 1'b1;
        b_in_data   = data;
        b_msb_first = msb;
        #1 check("b_in_ready_accept", 32'(b_in_ready), 32'd1);
        for (int unsigned t = 1; t <= W + 2; t++) begin
            @(negedge clk);
            if (t <= W) begin
                check("b_sout", 32'(b_sout), 32'(msb ? data[W-t] : data[t-1]));
                check("b_sout_valid", 32'(b_sout_valid), 32'd1);
            end else if (t == W + 1) begin
                check("b_rx_valid", 32'(b_rx_valid), 32'd1);
                check("b_rx_data", 32'(b_rx_data), 32'(data));
            end else begin
                check("b_rx_valid_idle", 32'(b_rx_valid), 32'd0);
                check("b_busy_idle", 32'(b_busy), 32'd0);
            end
            b_in_valid = 1'b0;
            b_in_data  = W'($urandom);
            if (t == W + 2) begin
                #1 check("b_in_ready_return", 32'(b_in_ready), 32'd1);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        msb_first   = 1'b0;
        abort       = 1'b0;
        sin         = 1'b0;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_msb_first = 1'b0;
        b_abort     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sout", 32'(sout), 32'd0);
        check("rst_sout_valid", 32'(sout_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_b_busy", 32'(b_busy), 32'd0);
        rst = 1'b0;
        #1 check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_b_in_ready", 32'(b_in_ready), 32'd1);

        // DIV=1 loopback, MSB first then LSB first, then random words.
        loop1(4'b1011, 1'b1);
        loop1(4'b1011, 1'b0);
        for (int n = 0; n < 6; n++) loop1(W'($urandom), 1'($urandom_range(0, 1)));

        // LSB first, sin 1,1,0,0 per bit period -> 4'b0011.
        xfer(4'b0001, 1'b0, 4'b0011, 0, 0);
        // Back-to-back accept, then abort in bit 2 followed by an immediate new accept.
        xfer(4'b1011, 1'b1, 4'b0110, 0, 0);
        xfer(4'b0110, 1'b1, 4'b1001, 1, 2);
        xfer(4'b1100, 1'b0, 4'b1010, 0, 0);

        // abort together with in_valid in IDLE blocks acceptance.
        abort    = 1'b1;
        in_valid = 1'b1;
        #1 check("collide_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("collide_busy", 32'(busy), 32'd0);
        abort    = 1'b0;
        in_valid = 1'b0;

        // Reset during DONE.
        xfer(4'b1111, 1'b1, 4'b0101, 2, 0);

        for (int n = 0; n < 24; n++) begin
            xfer(W'($urandom), 1'($urandom_range(0, 1)), W'($urandom),
                 ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, W - 1));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
